// File: rtl/mux8to1_32.sv
// Eight-input, 32-bit word multiplexer with one-hot select decode.
// Define MUX8T1_32_OREG_EN to add a reset-to-zero output register on o_q.
module mux8to1_32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] I0,
  input  logic [31:0] I1,
  input  logic [31:0] I2,
  input  logic [31:0] I3,
  input  logic [31:0] I4,
  input  logic [31:0] I5,
  input  logic [31:0] I6,
  input  logic [31:0] I7,
  input  logic [2:0]  s,
  output logic [31:0] o,
  output logic [31:0] o_q,
  output logic [7:0]  sel_oh
);

  // Word select as a flat full case; an unknown select yields zero in simulation.
  always_comb begin
    o = 32'h0000_0000;
    case (s)
      3'd0:    o = I0;
      3'd1:    o = I1;
      3'd2:    o = I2;
      3'd3:    o = I3;
      3'd4:    o = I4;
      3'd5:    o = I5;
      3'd6:    o = I6;
      3'd7:    o = I7;
      default: o = 32'h0000_0000;
    endcase
  end

  // One-hot decode of the select.
  always_comb begin
    sel_oh = 8'h00;
    case (s)
      3'd0:    sel_oh = 8'h01;
      3'd1:    sel_oh = 8'h02;
      3'd2:    sel_oh = 8'h04;
      3'd3:    sel_oh = 8'h08;
      3'd4:    sel_oh = 8'h10;
      3'd5:    sel_oh = 8'h20;
      3'd6:    sel_oh = 8'h40;
      3'd7:    sel_oh = 8'h80;
      default: sel_oh = 8'h00;
    endcase
  end

`ifdef MUX8T1_32_OREG_EN
  // Output register: clears asynchronously, captures o on each rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_q <= 32'h0000_0000;
    end else begin
      o_q <= o;
    end
  end
`else
  // Clock and reset stay on the port list so both builds share one footprint.
  logic unused_ports;
  assign unused_ports = clk ^ rst_n;
  assign o_q = o;
`endif

endmodule

// File: tb/tb_mux8to1_32.sv
// Self-checking bench for mux8to1_32: select sweep table, data-follow and
// output-register sequences, expectations queued and compared on output.
`timescale 1ns/100ps
module tb_mux8to1_32;

  logic        clk;
  logic        rst_n;
  logic [31:0] I0, I1, I2, I3, I4, I5, I6, I7;
  logic [2:0]  s;
  logic [31:0] o;
  logic [31:0] o_q;
  logic [7:0]  sel_oh;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          sel;
    logic [31:0] exp_o;
    logic [7:0]  exp_oh;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] exp_o;
    logic [7:0]  exp_oh;
  } exp_t;

  vec_t vecs[9];
  exp_t sb[$];

  mux8to1_32 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .I0     (I0),
    .I1     (I1),
    .I2     (I2),
    .I3     (I3),
    .I4     (I4),
    .I5     (I5),
    .I6     (I6),
    .I7     (I7),
    .s      (s),
    .o      (o),
    .o_q    (o_q),
    .sel_oh (sel_oh)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic load_data();
    I0 = 32'hAA55_0000; I1 = 32'h55AA_1111; I2 = 32'hAA55_2222; I3 = 32'h55AA_3333;
    I4 = 32'hAA55_4444; I5 = 32'h55AA_5555; I6 = 32'hAA55_6666; I7 = 32'h55AA_7777;
  endtask

  // Pop the oldest expectation and compare it with the combinational outputs.
  task automatic pop_compare();
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard: queue empty, expected an entry");
    end else begin
      e = sb.pop_front();
      check32({e.name, "_o"}, o, e.exp_o);
      check8({e.name, "_sel_oh"}, sel_oh, e.exp_oh);
`ifndef MUX8T1_32_OREG_EN
      check32({e.name, "_o_q"}, o_q, e.exp_o);
`endif
    end
  endtask

  initial begin
    vecs[0] = '{0, 32'hAA55_0000, 8'h01};
    vecs[1] = '{1, 32'h55AA_1111, 8'h02};
    vecs[2] = '{2, 32'hAA55_2222, 8'h04};
    vecs[3] = '{3, 32'h55AA_3333, 8'h08};
    vecs[4] = '{4, 32'hAA55_4444, 8'h10};
    vecs[5] = '{5, 32'h55AA_5555, 8'h20};
    vecs[6] = '{6, 32'hAA55_6666, 8'h40};
    vecs[7] = '{7, 32'h55AA_7777, 8'h80};
    vecs[8] = '{8, 32'hAA55_0000, 8'h01};

    load_data();
    rst_n = 1'b0;
    s     = 3'd0;
    #12;
    rst_n = 1'b1;
    #3;

    // Select sweep plus the wrap from a wider source.
    for (int i = 0; i < 9; i++) begin
      s = 3'(vecs[i].sel);
      sb.push_back('{$sformatf("sweep%0d", vecs[i].sel), vecs[i].exp_o, vecs[i].exp_oh});
      #1;
      pop_compare();
      #49;
    end

    // Data change on the selected input shows up without a clock edge.
    @(posedge clk);
    #2;
    s  = 3'd5;
    I5 = 32'hDEAD_BEEF;
    sb.push_back('{"follow_i5", 32'hDEAD_BEEF, 8'h20});
    #1;
    pop_compare();
    I4 = 32'h0000_0000;
    sb.push_back('{"ignore_i4", 32'hDEAD_BEEF, 8'h20});
    #1;
    pop_compare();
    load_data();

`ifdef MUX8T1_32_OREG_EN
    // Reset holds o_q at zero while o keeps following the select.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    s     = 3'd3;
    #1;
    check32("rst_o_q", o_q, 32'h0000_0000);
    check32("rst_o", o, 32'h55AA_3333);
    @(posedge clk);
    #1;
    check32("rst_hold_o_q", o_q, 32'h0000_0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check32("release_o_q", o_q, 32'h55AA_3333);

    // Late select change: o moves first, o_q at the following edge.
    s = 3'd1;
    @(posedge clk);
    #1;
    check32("pre_o_q", o_q, 32'h55AA_1111);
    #7;
    s = 3'd6;
    #1;
    check32("late_o", o, 32'hAA55_6666);
    check32("late_o_q_old", o_q, 32'h55AA_1111);
    #2;
    check32("late_o_q_new", o_q, 32'hAA55_6666);

    // Asynchronous clear between edges.
    #2;
    rst_n = 1'b0;
    #1;
    check32("async_o_q", o_q, 32'h0000_0000);
    check32("async_o", o, 32'hAA55_6666);
    @(negedge clk);
    rst_n = 1'b1;
`else
    // Pass-through o_q ignores reset and clock.
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s = 3'(vecs[i].sel);
      #3;
      check32($sformatf("pass_rst%0d", i), o_q, vecs[i].exp_o);
    end
    rst_n = 1'b1;
`endif

    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
